// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, ALU operation classes and the decoded control word.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [1:0] {
    AluAdd   = 2'b00,
    AluSub   = 2'b01,
    AluFunct = 2'b10,
    AluXor   = 2'b11
  } aluop_e;

  // Full decode word as produced by the control unit.
  typedef struct packed {
    logic   regdst;
    logic   alusrc;
    logic   memtoreg;
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   branch;
    logic   jump;
    logic   signzero;
    aluop_e aluop;
  } ctrl_t;

  // Control carried into EX; signzero is consumed before capture.
  typedef struct packed {
    logic   regdst;
    logic   alusrc;
    logic   memtoreg;
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   branch;
    logic   jump;
    aluop_e aluop;
  } ex_ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register a load in EX writes.
module hazard_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              id_jump_i,
  input  logic              id_regdst_i,
  input  logic              id_memwrite_i,
  input  logic              id_branch_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              ex_valid_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  output logic              hz_o
);

  logic uses_rs;
  logic uses_rt;

  assign uses_rs = ~id_jump_i;
  // rt is a source only for R-type, stores and branches; I-type ALU ops write it.
  assign uses_rt = id_regdst_i | id_memwrite_i | id_branch_i;

  assign hz_o = ex_valid_i & ex_memread_i & (ex_rt_i != '0) &
                ((uses_rs & (ex_rt_i == id_rs_i)) | (uses_rt & (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush squash and saturating event counters.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_regdst,
  input  logic              id_alusrc,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_branch,
  input  logic              id_jump,
  input  logic              id_signzero,
  input  logic [1:0]        id_aluop,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [15:0]       id_imm16,
  input  logic              flush_i,
  output logic              ex_regdst,
  output logic              ex_alusrc,
  output logic              ex_memtoreg,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic [1:0]        ex_aluop,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  ctrl_t             id_ctrl, ctrl_d;
  ex_ctrl_t          ex_ctrl_d, ex_ctrl_q;
  logic              hz, capture;
  logic              valid_d, valid_q;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] pc4_d, pc4_q, rdata1_d, rdata1_q, rdata2_d, rdata2_q, imm_d, imm_q;
  logic [REG_AW-1:0] rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
  logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

  assign id_ctrl = '{regdst: id_regdst, alusrc: id_alusrc, memtoreg: id_memtoreg,
                     regwrite: id_regwrite, memread: id_memread, memwrite: id_memwrite,
                     branch: id_branch, jump: id_jump, signzero: id_signzero,
                     aluop: aluop_e'(id_aluop)};

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .id_jump_i     (id_jump),
    .id_regdst_i   (id_regdst),
    .id_memwrite_i (id_memwrite),
    .id_branch_i   (id_branch),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .ex_valid_i    (valid_q),
    .ex_memread_i  (ex_ctrl_q.memread),
    .ex_rt_i       (rt_q),
    .hz_o          (hz)
  );

  // Flush wins over a hazard: the squashed instruction must not hold the front end.
  assign stall_o = hz & ~flush_i;
  assign capture = ~flush_i & ~hz;

  always_comb begin
    ctrl_d  = capture ? id_ctrl : BUBBLE_CTRL;
    imm_ext = ctrl_d.signzero ? {{(DATA_W-16){1'b0}}, id_imm16}
                              : {{(DATA_W-16){id_imm16[15]}}, id_imm16};
    ex_ctrl_d = '{regdst: ctrl_d.regdst, alusrc: ctrl_d.alusrc, memtoreg: ctrl_d.memtoreg,
                  regwrite: ctrl_d.regwrite, memread: ctrl_d.memread,
                  memwrite: ctrl_d.memwrite, branch: ctrl_d.branch, jump: ctrl_d.jump,
                  aluop: ctrl_d.aluop};
    valid_d  = capture;
    pc4_d    = capture ? id_pc4 : '0;
    rdata1_d = capture ? id_rdata1 : '0;
    rdata2_d = capture ? id_rdata2 : '0;
    imm_d    = capture ? imm_ext : '0;
    rs_d     = capture ? id_rs : '0;
    rt_d     = capture ? id_rt : '0;
    rd_d     = capture ? id_rd : '0;

    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (flush_i && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_ctrl_q   <= '0;
      valid_q     <= 1'b0;
      pc4_q       <= '0;
      rdata1_q    <= '0;
      rdata2_q    <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_ctrl_q   <= ex_ctrl_d;
      valid_q     <= valid_d;
      pc4_q       <= pc4_d;
      rdata1_q    <= rdata1_d;
      rdata2_q    <= rdata2_d;
      imm_q       <= imm_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_regdst   = ex_ctrl_q.regdst;
  assign ex_alusrc   = ex_ctrl_q.alusrc;
  assign ex_memtoreg = ex_ctrl_q.memtoreg;
  assign ex_regwrite = ex_ctrl_q.regwrite;
  assign ex_memread  = ex_ctrl_q.memread;
  assign ex_memwrite = ex_ctrl_q.memwrite;
  assign ex_branch   = ex_ctrl_q.branch;
  assign ex_jump     = ex_ctrl_q.jump;
  assign ex_aluop    = ex_ctrl_q.aluop;
  assign ex_valid    = valid_q;
  assign ex_pc4      = pc4_q;
  assign ex_rdata1   = rdata1_q;
  assign ex_rdata2   = rdata2_q;
  assign ex_imm      = imm_q;
  assign ex_rs       = rs_q;
  assign ex_rt       = rt_q;
  assign ex_rd       = rd_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage MIPS core; sits directly downstream of the decode control unit.
- Captures the decoded control word, register operands, register specifiers and the extended immediate each cycle.
- Detects load-use hazards, stalls IF/ID and inserts bubbles. Squashes on branch/jump flush.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register specifier width
- CNT_W, 16, width of the stall and flush counters

Ports:
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- id_regdst, id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_jump, id_signzero  in  1 each  control bits from decode
- id_aluop  in  2  ALU operation class from decode
- id_pc4  in  DATA_W  PC+4 of the ID instruction
- id_rdata1, id_rdata2  in  DATA_W  register file read data
- id_rs, id_rt, id_rd  in  REG_AW  specifiers
- id_imm16  in  16  raw immediate
- flush_i  in  1  branch/jump taken; squash the ID instruction
- ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jump  out  1 each  registered control
- ex_aluop  out  2  registered ALU class
- ex_valid  out  1  EX slot holds a real instruction
- ex_pc4, ex_rdata1, ex_rdata2, ex_imm  out  DATA_W  registered data; ex_imm is already extended
- ex_rs, ex_rt, ex_rd  out  REG_AW  registered specifiers
- stall_o  out  1  combinational; holds PC and IF/ID
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- Reset: one clock, asynchronous active-low reset (reset_n). Assertion immediately clears every ex_* output, ex_valid, stall_cnt and flush_cnt to 0. Reset mid-stall drops the held instruction; stall_o then follows the cleared state (0).
- Latency: 1 cycle. ID values on edge N appear on ex_* after edge N.
- Immediate extension: id_signzero=1 zero-extends id_imm16. Otherwise it sign-extends to DATA_W. Extension happens before capture.
- Source use, derived from ID control:
  - uses_rs = !id_jump
  - uses_rt = id_regdst | id_memwrite | id_branch
- Load-use hazard, combinational:
  - hz = ex_valid & ex_memread & (ex_rt != 0) & ((uses_rs & ex_rt == id_rs) | (uses_rt & ex_rt == id_rt))
  - stall_o = hz & !flush_i
- Priority at each rising edge:
  1. flush_i=1: capture a bubble. stall_o is 0. flush_cnt increments. Flush overrides a simultaneous hazard.
  2. else stall_o=1: capture a bubble. The ID instruction stays held upstream and is re-presented next cycle. stall_cnt increments.
  3. else: capture the ID instruction with ex_valid=1.
- Bubble definition:
  - All ex_* control bits 0, ex_aluop=2'b00, ex_valid=0.
  - Data and specifier fields are zeroed, so ex_rt=0 and a bubble can never trigger a hazard.
- An all-zero opcode word is captured as valid (R-type sll $0 = nop). Only bubbles clear ex_valid.
- Counters saturate at all-ones and never wrap.
- A stall lasts exactly one cycle per lw→use pair, because the bubble clears ex_memread. Back-to-back lw→lw→use causes only the single stall mandated by the hazard term.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants: R=000000, LW=100011, SW=101011, BNE=000101, XORI=001110, J=000010.
  - ALUOp encodings: 00 add, 01 sub, 10 funct, 11 xor.
  - ctrl_t packed struct for the 9 control bits plus aluop.
  - BUBBLE_CTRL constant (all zeros).
- One sub-module, hazard_detect (combinational): takes the ID control/specifiers and the EX memread/rt/valid, and produces hz.

Test Plan:
- lw $2,0($1) then add $3,$2,$4 (id_rs=2): stall_o=1 for exactly one cycle. EX receives a bubble (ex_valid=0, ex_regwrite=0), then the add with ex_rs=2. stall_cnt=1.
- lw $2 then xori $2,$5,0xFFFF (rt is destination only, rs=5): no stall. ex_imm=0x0000FFFF. addi-style sign path with imm 0x8000 and signzero=0 gives ex_imm=0xFFFF8000.
- lw $0,4($1) then add $3,$0,$0: ex_rt=0, so no stall.
- lw $2 then sw $2,8($6) (uses rt=2): stall 1 cycle. Same pattern with flush_i=1 in the hazard cycle: stall_o=0, bubble captured, flush_cnt=1, stall_cnt unchanged.
- Force 0xFFFF stalls: stall_cnt holds at 0xFFFF. Assert reset_n=0 asynchronously mid-cycle: all outputs 0 before the next clock edge.
